// File: rtl/stim_sig_harness.sv
// stim_sig_harness
//
// On-chip stimulus/response harness for fuzz-generated designs. A Galois
// LFSR produces NUM_VEC stimulus vectors on the concatenated DUT input bus,
// and a MISR folds the DUT response into one SIG_W-bit signature. The
// response is captured LAT clocks after each vector to cover the DUT
// latency. The overall result of a run is a single signature compare.
//
// Parameters:
//   DATA_W   stimulus width (>= 2)
//   RESP_W   DUT response width
//   SIG_W    signature width (>= 2)
//   NUM_VEC  vectors per run (>= 1)
//   LAT      DUT response latency in clocks (>= 0)
//   SEED     LFSR seed (0 is replaced by 1)
//   TAPS     Galois LFSR feedback mask
//   SIG_POLY MISR feedback polynomial
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   begin a run (acted on in IDLE or DONE only)
//   resp       in   DUT output bus [RESP_W]
//   golden     in   expected signature [SIG_W]
//   stim       out  DUT input bus [DATA_W]
//   stim_valid out  stim holds a live vector
//   busy       out  run or drain in progress
//   done       out  run complete, held until the next start
//   signature  out  current MISR value [SIG_W]
//   pass       out  done and signature matches golden
//
// Build option:
//   STIM_SIG_GOLDEN_CMP_EN  when defined, pass is a registered
//                           done && (signature == golden); otherwise golden
//                           is ignored and pass is tied low.

module stim_sig_harness #(
    parameter int                DATA_W   = 256,
    parameter int                RESP_W   = 635,
    parameter int                SIG_W    = 32,
    parameter int                NUM_VEC  = 21,
    parameter int                LAT      = 0,
    parameter logic [DATA_W-1:0] SEED     = DATA_W'(1),
    parameter logic [DATA_W-1:0] TAPS     = DATA_W'(8'hB8),
    parameter logic [SIG_W-1:0]  SIG_POLY = SIG_W'(32'h04C11DB7)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RESP_W-1:0] resp,
    input  logic [SIG_W-1:0]  golden,
    output logic [DATA_W-1:0] stim,
    output logic              stim_valid,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic              pass
);

    localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? DATA_W'(1) : SEED;
    localparam int CNT_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int DRN_W  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int LAT_M1 = (LAT > 0) ? LAT - 1 : 0;
    localparam int NSLICE = (RESP_W + SIG_W - 1) / SIG_W;
    localparam int PAD_W  = NSLICE * SIG_W;

    localparam logic [CNT_W-1:0] LAST_VEC  = CNT_W'(NUM_VEC - 1);
    localparam logic [DRN_W-1:0] LAST_DRN  = DRN_W'(LAT_M1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Galois LFSR step: shift right, fold taps back in when a one falls out.
    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    // XOR of all SIG_W-wide slices of the response; the top slice is
    // zero-padded when RESP_W is not a multiple of SIG_W.
    function automatic logic [SIG_W-1:0] resp_fold(input logic [RESP_W-1:0] r);
        logic [PAD_W-1:0] padded;
        logic [SIG_W-1:0] acc;
        padded = PAD_W'(r);
        acc    = '0;
        for (int i = 0; i < NSLICE; i++) begin
            acc = acc ^ padded[i*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

    // MISR step: shift left with polynomial feedback, then absorb the fold.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [SIG_W-1:0] f);
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? SIG_POLY : '0) ^ f;
    endfunction

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] vec_cnt;
    logic [DRN_W-1:0] drn_cnt;
    logic             load;
    logic             adv;
    logic             cap_vld;
    logic [SIG_W-1:0] sig_d;

    // ------------------------------------------------------------------
    // Control: state register and next-state decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                adv = 1'b1;
                if (vec_cnt == LAST_VEC) begin
                    state_d = (LAT > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (drn_cnt == LAST_DRN) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are flops loaded from the next state so they line up
    // with the state register rather than decoding it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            stim_valid <= (state_d == S_RUN);
            busy       <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done       <= (state_d == S_DONE);
        end
    end

    // Vector and drain counters. vec_cnt saturates at the last vector so
    // it never wraps on the exit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt <= '0;
            drn_cnt <= '0;
        end else begin
            if (load) begin
                vec_cnt <= '0;
            end else if (adv && (vec_cnt != LAST_VEC)) begin
                vec_cnt <= vec_cnt + 1'b1;
            end
            if (state_q == S_DRAIN) begin
                drn_cnt <= drn_cnt + 1'b1;
            end else begin
                drn_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage p0: stimulus generation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim <= '0;
        end else if (load) begin
            stim <= SEED_EFF;
        end else if (adv) begin
            stim <= lfsr_step(stim);
        end
    end

    // ------------------------------------------------------------------
    // Stage p1..pLAT: valid delay matching the DUT latency
    // ------------------------------------------------------------------
    generate
        if (LAT == 0) begin : g_no_lat
            assign cap_vld = stim_valid;
        end else begin : g_lat
            logic [LAT-1:0] vld_p;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p <= '0;
                end else if (load) begin
                    vld_p <= '0;
                end else begin
                    vld_p <= LAT'({vld_p, stim_valid});
                end
            end
            assign cap_vld = vld_p[LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response capture: MISR signature
    // ------------------------------------------------------------------
    always_comb begin
        sig_d = signature;
        if (load) begin
            sig_d = '0;
        end else if (cap_vld) begin
            sig_d = misr_step(signature, resp_fold(resp));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signature <= '0;
        end else begin
            signature <= sig_d;
        end
    end

    // ------------------------------------------------------------------
    // Verdict
    // ------------------------------------------------------------------
`ifdef STIM_SIG_GOLDEN_CMP_EN
    // Evaluated against the next-state signature so pass rises on the same
    // edge as done; tracks golden while the harness sits in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass <= 1'b0;
        end else begin
            pass <= (state_d == S_DONE) && (sig_d == golden);
        end
    end
`else
    assign pass = 1'b0;
    logic unused_golden;
    assign unused_golden = ^golden;
`endif

endmodule

// File: tb/tb_stim_sig_harness.sv
// Directed bench for stim_sig_harness. Instance A: 8-bit LFSR, 20-bit
// response folded into an 8-bit MISR, zero latency. Instance B: zero seed,
// 8-bit response, three clocks of DUT latency.
module tb_stim_sig_harness;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef STIM_SIG_GOLDEN_CMP_EN
    localparam logic CMP_ON = 1'b1;
`else
    localparam logic CMP_ON = 1'b0;
`endif

    logic        a_start;
    logic [19:0] a_resp;
    logic [7:0]  a_golden;
    logic [7:0]  a_stim;
    logic        a_stim_valid;
    logic        a_busy;
    logic        a_done;
    logic [7:0]  a_signature;
    logic        a_pass;

    logic        b_start;
    logic [7:0]  b_resp;
    logic [7:0]  b_golden;
    logic [7:0]  b_stim;
    logic        b_stim_valid;
    logic        b_busy;
    logic        b_done;
    logic [7:0]  b_signature;
    logic        b_pass;

    stim_sig_harness #(
        .DATA_W(8), .RESP_W(20), .SIG_W(8), .NUM_VEC(6), .LAT(0),
        .SEED(8'h01), .TAPS(8'hB8), .SIG_POLY(8'h1D)
    ) u_a (
        .clk(clk), .rst(rst), .start(a_start), .resp(a_resp), .golden(a_golden),
        .stim(a_stim), .stim_valid(a_stim_valid), .busy(a_busy), .done(a_done),
        .signature(a_signature), .pass(a_pass)
    );

    stim_sig_harness #(
        .DATA_W(8), .RESP_W(8), .SIG_W(8), .NUM_VEC(2), .LAT(3),
        .SEED(8'h00), .TAPS(8'hB8), .SIG_POLY(8'h1D)
    ) u_b (
        .clk(clk), .rst(rst), .start(b_start), .resp(b_resp), .golden(b_golden),
        .stim(b_stim), .stim_valid(b_stim_valid), .busy(b_busy), .done(b_done),
        .signature(b_signature), .pass(b_pass)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] lfsr_exp [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    // resp = 20'hABCDE folds to 8'h68 each clock
    logic [7:0] sig_abc  [6] = '{8'h68, 8'hB8, 8'h05, 8'h62, 8'hAC, 8'h2D};
    // resp = 20'h00001 folds to 8'h01 each clock
    logic [7:0] sig_one  [6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_start = 1'b0; a_resp = '0; a_golden = '0;
        b_start = 1'b0; b_resp = '0; b_golden = '0;

        // Reset state
        #12;
        chk("rst_a_stim", 32'(a_stim), 32'h0);
        chk("rst_a_valid", 32'(a_stim_valid), 32'h0);
        chk("rst_a_busy", 32'(a_busy), 32'h0);
        chk("rst_a_done", 32'(a_done), 32'h0);
        chk("rst_a_sig", 32'(a_signature), 32'h0);
        chk("rst_a_pass", 32'(a_pass), 32'h0);
        chk("rst_b_done", 32'(b_done), 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_a_busy", 32'(a_busy), 32'h0);

        // LFSR sequence, zero response, golden 00
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("lfsr_stim0", 32'(a_stim), 32'h01);
        chk("lfsr_valid0", 32'(a_stim_valid), 32'h1);
        chk("lfsr_busy0", 32'(a_busy), 32'h1);
        chk("lfsr_done0", 32'(a_done), 32'h0);
        for (int k = 1; k < 6; k++) begin
            tick();
            chk("lfsr_stim", 32'(a_stim), 32'(lfsr_exp[k]));
            chk("lfsr_valid", 32'(a_stim_valid), 32'h1);
        end
        tick();
        chk("lfsr_end_valid", 32'(a_stim_valid), 32'h0);
        chk("lfsr_end_done", 32'(a_done), 32'h1);
        chk("lfsr_end_busy", 32'(a_busy), 32'h0);
        chk("zero_sig", 32'(a_signature), 32'h00);
        chk("zero_pass", 32'(a_pass), 32'(CMP_ON));

        // Multi-slice fold 20'hABCDE, restart from DONE
        a_resp   = 20'hABCDE;
        a_golden = 8'h2D;
        a_start  = 1'b1;
        tick();
        a_start = 1'b0;
        chk("abc_done_drop", 32'(a_done), 32'h0);
        chk("abc_stim0", 32'(a_stim), 32'h01);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abc_sig", 32'(a_signature), 32'(sig_abc[k]));
        end
        chk("abc_done", 32'(a_done), 32'h1);
        chk("abc_pass", 32'(a_pass), 32'(CMP_ON));
        a_golden = 8'h2C;
        tick();
        chk("abc_pass_bad_golden", 32'(a_pass), 32'h0);
        chk("abc_sig_stable", 32'(a_signature), 32'h2D);

        // resp 1: signature cleared on start, then 01, 03, ...
        a_resp   = 20'h00001;
        a_golden = 8'h3F;
        a_start  = 1'b1;
        tick();
        a_start = 1'b0;
        chk("one_sig_clear", 32'(a_signature), 32'h00);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("one_sig", 32'(a_signature), 32'(sig_one[k]));
        end
        chk("one_pass", 32'(a_pass), 32'(CMP_ON));

        // Asynchronous reset mid-run, after 3 vectors
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        tick();
        chk("mid_stim_before_rst", 32'(a_stim), 32'h5C);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stim", 32'(a_stim), 32'h0);
        chk("arst_valid", 32'(a_stim_valid), 32'h0);
        chk("arst_busy", 32'(a_busy), 32'h0);
        chk("arst_done", 32'(a_done), 32'h0);
        chk("arst_sig", 32'(a_signature), 32'h0);
        chk("arst_pass", 32'(a_pass), 32'h0);
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 32'(a_busy), 32'h0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("rerun_stim0", 32'(a_stim), 32'h01);
        chk("rerun_valid0", 32'(a_stim_valid), 32'h1);
        for (int k = 1; k < 6; k++) begin
            tick();
            chk("rerun_stim", 32'(a_stim), 32'(lfsr_exp[k]));
            chk("rerun_valid", 32'(a_stim_valid), 32'h1);
        end
        tick();
        chk("rerun_valid_end", 32'(a_stim_valid), 32'h0);
        chk("rerun_done", 32'(a_done), 32'h1);
        chk("rerun_sig", 32'(a_signature), 32'h3F);

        // Latency 3, zero seed, start during DRAIN ignored
        b_resp   = 8'hFF;
        b_golden = 8'h06;
        b_start  = 1'b1;
        tick();
        b_start = 1'b0;
        chk("lat_stim0", 32'(b_stim), 32'h01);
        chk("lat_valid0", 32'(b_stim_valid), 32'h1);
        chk("lat_busy0", 32'(b_busy), 32'h1);
        tick();
        chk("lat_stim1", 32'(b_stim), 32'hB8);
        chk("lat_valid1", 32'(b_stim_valid), 32'h1);
        tick();
        chk("lat_drain_valid", 32'(b_stim_valid), 32'h0);
        chk("lat_drain_busy", 32'(b_busy), 32'h1);
        chk("lat_drain_done", 32'(b_done), 32'h0);
        chk("lat_drain_sig", 32'(b_signature), 32'h00);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("lat_e3_busy", 32'(b_busy), 32'h1);
        chk("lat_e3_sig", 32'(b_signature), 32'h00);
        b_resp = 8'h01;
        tick();
        chk("lat_cap0_sig", 32'(b_signature), 32'h01);
        chk("lat_cap0_done", 32'(b_done), 32'h0);
        b_resp = 8'h04;
        tick();
        chk("lat_cap1_sig", 32'(b_signature), 32'h06);
        chk("lat_done", 32'(b_done), 32'h1);
        chk("lat_busy_end", 32'(b_busy), 32'h0);
        chk("lat_pass", 32'(b_pass), 32'(CMP_ON));
        b_resp = 8'hFF;
        tick();
        chk("lat_sig_hold", 32'(b_signature), 32'h06);
        chk("lat_done_hold", 32'(b_done), 32'h1);
        chk("lat_no_restart", 32'(b_busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stim_sig_harness.md
# stim_sig_harness

Synthesisable, parametrised stimulus/response harness for fuzz-generated designs. It replaces the hard-coded vector list and per-clock `$strobe` dump with two on-chip parts: an LFSR that generates a configurable number of stimulus vectors, and a MISR that compresses the DUT response into one signature. It sits between the bench and `top`, driving the concatenated DUT inputs and sampling the DUT output bus. Pass/fail is reduced to a single signature compare.

## Interface
- DATA_W, 256: stimulus width (concatenated DUT inputs), ≥ 2
- RESP_W, 635: DUT response width
- SIG_W, 32: signature width, ≥ 2
- NUM_VEC, 21: vectors per run, ≥ 1
- LAT, 0: DUT response latency in clocks, ≥ 0
- SEED, 1: LFSR seed; 0 is replaced by 1
- TAPS, DATA_W'h…B8 (low byte 8'hB8): Galois LFSR feedback mask
- SIG_POLY, 32'h04C11DB7: MISR feedback polynomial (low SIG_W bits used)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled in IDLE or DONE only
- resp  in  RESP_W  DUT output bus
- golden  in  SIG_W  expected signature
- stim  out  DATA_W  DUT input bus
- stim_valid  out  1  stim holds a live vector
- busy  out  1  state is RUN or DRAIN
- done  out  1  run complete; held until next start
- signature  out  SIG_W  current MISR value
- pass  out  1  done && signature == golden (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE + start: stim ← SEED (or 1 if SEED==0), vec_cnt ← 0, signature ← 0, clear valid pipe, → RUN.
- RUN: stim_valid=1. Each clock: stim ← (stim>>1) ^ (stim[0] ? TAPS : 0); vec_cnt++. When vec_cnt reaches NUM_VEC−1: → DRAIN if LAT>0, else → DONE.
- DRAIN: stim_valid=0, stim holds. Lasts exactly LAT clocks, then → DONE.
- Response capture: stim_valid is delayed LAT clocks (cap_vld; LAT=0 means cap_vld=stim_valid). When cap_vld=1: fold = XOR of all SIG_W-bit slices of resp (last slice zero-padded); signature ← {signature[SIG_W−2:0],0} ^ (signature[SIG_W−1] ? SIG_POLY : 0) ^ fold.
- start during RUN/DRAIN is ignored. start in DONE restarts immediately; done drops on that edge.
- Reset is asynchronous: on rst, state=IDLE, stim=0, stim_valid=0, busy=0, done=0, signature=0, pass=0, vec_cnt=0, valid pipe cleared, irrespective of mid-run state.

## Timing
- start sampled at edge E0 → stim_valid high for clocks E0..E0+NUM_VEC−1 (exactly NUM_VEC vectors); first vector = seed.
- Final MISR update at edge E0+NUM_VEC+LAT; done and pass valid from that edge.
- Total run length NUM_VEC+LAT clocks; signature stable in DONE.
- All outputs registered; no combinational path from resp or start to any output.

## Configuration
- STIM_SIG_GOLDEN_CMP_EN defined: pass = done && (signature == golden), registered.
- Not defined: golden ignored, pass tied to 0, no comparator synthesised; the bench compares signature itself.

## Test plan
- DATA_W=8, TAPS=8'hB8, SEED=8'h01, NUM_VEC=6, start pulse → stim sequence 01, B8, 5C, 2E, 17, B3 with stim_valid high exactly 6 clocks; done one clock after last vector (LAT=0).
- SIG_W=8, SIG_POLY=8'h1D, RESP_W=8, resp=8'h00, NUM_VEC=4 → signature=8'h00; golden=8'h00 → pass=1 (macro on), pass=0 (macro off).
- Same config, resp=8'h01, NUM_VEC=2 → signature 01 then 03; golden=8'h03 → pass=1; golden=8'h04 → pass=0.
- LAT=3, NUM_VEC=2, resp changes only 3 clocks after each stim → exactly 2 captures, done at start+5; start pulsed during DRAIN ignored.
- rst asserted mid-RUN (after 3 vectors) → all outputs 0 asynchronously; new start yields seed first and full NUM_VEC vectors.
- SEED=0 → first vector 01; RESP_W=20, SIG_W=8, resp=20'hABCDE → fold = DE^BC^0A = 8'h68.
